// File: rtl/ex_mdu_if.sv
// ex_mdu_if: operand/command and result bundle between the EX stage and the
// multiply/divide unit. The master side is the pipeline, the slave side is the MDU.
interface ex_mdu_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        cancel;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, op, SrcA, SrcB, cancel,
                   input  busy, HI, LO);
   modport slave  (input  start, op, SrcA, SrcB, cancel,
                   output busy, HI, LO);
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// The result is computed when the operation is accepted. It is then held as a
// pending value until the counter expires and is committed on that edge.
// Optional build macro MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7..10).
module ex_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic    clk,
   input  logic    reset_n,
   ex_mdu_if.slave mdu
);

   typedef enum logic [0:0] {S_IDLE, S_BUSY} state_e;
   typedef enum logic [1:0] {K_NONE, K_SET, K_ADD, K_SUB} kind_e;
   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } op_e;

   localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

   state_e      r_state;
   state_e      w_state_nxt;
   kind_e       r_kind;
   kind_e       w_kind;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cycles;
   logic [63:0] r_pend;
   logic [63:0] w_result;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        w_accept;
   logic        w_long;
   logic        w_commit;

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_b_zero;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_sden;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_squo;
   logic [31:0] w_srem;
   logic [31:0] w_uden;
   logic [31:0] w_uquo;
   logic [31:0] w_urem;

   assign w_accept = mdu.start && !mdu.cancel && (r_state == S_IDLE);

   // Arithmetic: full 64-bit products and sign-corrected magnitude division
   always_comb begin
      w_prod_s = {{32{mdu.SrcA[31]}}, mdu.SrcA} * {{32{mdu.SrcB[31]}}, mdu.SrcB};
      w_prod_u = {32'd0, mdu.SrcA} * {32'd0, mdu.SrcB};
      w_b_zero = (mdu.SrcB == '0);
      // 0x80000000 has no positive twin; its magnitude reads back correctly as unsigned
      w_a_mag  = mdu.SrcA[31] ? (32'd0 - mdu.SrcA) : mdu.SrcA;
      w_b_mag  = mdu.SrcB[31] ? (32'd0 - mdu.SrcB) : mdu.SrcB;
      w_sden   = w_b_zero ? 32'd1 : w_b_mag;
      w_uq     = w_a_mag / w_sden;
      w_ur     = w_a_mag % w_sden;
      w_squo   = (mdu.SrcA[31] ^ mdu.SrcB[31]) ? (32'd0 - w_uq) : w_uq;
      w_srem   = mdu.SrcA[31] ? (32'd0 - w_ur) : w_ur;
      w_uden   = w_b_zero ? 32'd1 : mdu.SrcB;
      w_uquo   = mdu.SrcA / w_uden;
      w_urem   = mdu.SrcA % w_uden;
   end

   // Op decode: classify long ops, pick cycle count and the pending result
   always_comb begin
      w_long   = 1'b0;
      w_kind   = K_NONE;
      w_cycles = '0;
      w_result = '0;
      case (mdu.op)
         OP_MULT: begin
            w_long   = 1'b1;
            w_kind   = K_SET;
            w_cycles = LP_MULT_N;
            w_result = w_prod_s;
         end
         OP_MULTU: begin
            w_long   = 1'b1;
            w_kind   = K_SET;
            w_cycles = LP_MULT_N;
            w_result = w_prod_u;
         end
         OP_DIV: begin
            w_long   = 1'b1;
            w_kind   = w_b_zero ? K_NONE : K_SET;
            w_cycles = LP_DIV_N;
            w_result = {w_srem, w_squo};
         end
         OP_DIVU: begin
            w_long   = 1'b1;
            w_kind   = w_b_zero ? K_NONE : K_SET;
            w_cycles = LP_DIV_N;
            w_result = {w_urem, w_uquo};
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            w_long   = 1'b1;
            w_kind   = K_ADD;
            w_cycles = LP_MULT_N;
            w_result = w_prod_s;
         end
         OP_MADDU: begin
            w_long   = 1'b1;
            w_kind   = K_ADD;
            w_cycles = LP_MULT_N;
            w_result = w_prod_u;
         end
         OP_MSUB: begin
            w_long   = 1'b1;
            w_kind   = K_SUB;
            w_cycles = LP_MULT_N;
            w_result = w_prod_s;
         end
         OP_MSUBU: begin
            w_long   = 1'b1;
            w_kind   = K_SUB;
            w_cycles = LP_MULT_N;
            w_result = w_prod_u;
         end
`endif
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state; commit fires on the edge the counter reaches its last cycle
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept && w_long) w_state_nxt = S_BUSY;
         S_BUSY: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_IDLE;
               w_commit    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch pending work, count down, write HI/LO on mt* or commit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_cnt  <= '0;
         r_pend <= '0;
         r_kind <= K_NONE;
      end else begin
         if (w_accept) begin
            if (w_long) begin
               r_cnt  <= w_cycles;
               r_pend <= w_result;
               r_kind <= w_kind;
            end else if (mdu.op == OP_MTHI) begin
               r_hi <= mdu.SrcA;
            end else if (mdu.op == OP_MTLO) begin
               r_lo <= mdu.SrcA;
            end
         end
         if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_commit) begin
               // accumulate uses HI/LO as they stand on the commit edge
               case (r_kind)
                  K_SET:   {r_hi, r_lo} <= r_pend;
                  K_ADD:   {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                  K_SUB:   {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
                  default: ;
               endcase
            end
         end
      end
   end

   assign mdu.busy = (r_state == S_BUSY);
   assign mdu.HI   = r_hi;
   assign mdu.LO   = r_lo;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and random checks of ex_mdu against an arithmetic
// reference model of HI/LO and busy duration.
module tb_ex_mdu;

   localparam int unsigned N_MULT = 5;
   localparam int unsigned N_DIV  = 10;
`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   ex_mdu_if u_if ();

   ex_mdu #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mdu     (u_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: result and busy length from the instruction semantics
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output int unsigned cyc,
                                  output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, acc, p;
      sa  = longint'(int'(a));
      sb  = longint'(int'(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      acc = {m_hi, m_lo};
      hi  = m_hi;
      lo  = m_lo;
      cyc = 0;
      case (op)
         4'd1: begin cyc = N_MULT; p = longint'(sa * sb); {hi, lo} = p; end
         4'd2: begin cyc = N_MULT; p = ua * ub; {hi, lo} = p; end
         4'd3: begin
            cyc = N_DIV;
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               lo = q[31:0];
               hi = r[31:0];
            end
         end
         4'd4: begin
            cyc = N_DIV;
            if (b != 0) begin
               lo = a / b;
               hi = a % b;
            end
         end
         4'd5: hi = a;
         4'd6: lo = a;
         4'd7, 4'd8, 4'd9, 4'd10: begin
            if (MADD) begin
               cyc = N_MULT;
               p = (op == 4'd7 || op == 4'd9) ? longint'(sa * sb) : ua * ub;
               {hi, lo} = (op <= 4'd8) ? acc + p : acc - p;
            end
         end
         default: ;
      endcase
   endfunction

   // Issue one op at a negedge; check busy and held values each cycle, then the result
   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
      int unsigned cyc;
      logic [31:0] eh, el;
      ref_op(op, a, b, cyc, eh, el);
      u_if.start  = 1'b1;
      u_if.op     = op;
      u_if.SrcA   = a;
      u_if.SrcB   = b;
      u_if.cancel = 1'b0;
      @(negedge clk);
      u_if.start = 1'b0;
      for (int unsigned i = 0; i < cyc; i++) begin
         chk({tag, "_busy"}, 64'(u_if.busy), 64'd1);
         chk({tag, "_hold"}, {u_if.HI, u_if.LO}, {m_hi, m_lo});
         @(negedge clk);
      end
      chk({tag, "_idle"}, 64'(u_if.busy), 64'd0);
      chk({tag, "_hilo"}, {u_if.HI, u_if.LO}, {eh, el});
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      int unsigned cyc;
      logic [31:0] eh, el;
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      reset_n     = 1'b0;
      u_if.start  = 1'b0;
      u_if.op     = 4'd0;
      u_if.SrcA   = '0;
      u_if.SrcB   = '0;
      u_if.cancel = 1'b0;
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(u_if.busy), 64'd0);
      chk("reset_hilo", {u_if.HI, u_if.LO}, 64'd0);
      reset_n = 1'b1;

      run_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult_neg");
      chk("mult_neg_abs", {u_if.HI, u_if.LO}, 64'hFFFFFFFF_FFFFFFFA);
      run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
      chk("multu_max_abs", {u_if.HI, u_if.LO}, 64'hFFFFFFFE_00000001);
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div_neg");
      chk("div_neg_abs", {u_if.HI, u_if.LO}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      chk("div_ovf_abs", {u_if.HI, u_if.LO}, 64'h00000000_80000000);
      run_op(4'd4, 32'd7, 32'd0, "divu_zero");
      run_op(4'd3, 32'd7, 32'd0, "div_zero");
      run_op(4'd4, 32'd100, 32'd7, "divu");
      run_op(4'd5, 32'h12345678, 32'd0, "mthi");
      run_op(4'd6, 32'h9ABCDEF0, 32'd0, "mtlo");
      chk("mt_abs", {u_if.HI, u_if.LO}, 64'h12345678_9ABCDEF0);
      run_op(4'd0, 32'h1111, 32'h2222, "op0");
      run_op(4'd15, 32'h1111, 32'h2222, "op15");

      // start held across completion: the queued mthi lands one edge later
      ref_op(4'd1, 32'd6, 32'd7, cyc, eh, el);
      u_if.start = 1'b1; u_if.op = 4'd1; u_if.SrcA = 32'd6; u_if.SrcB = 32'd7;
      @(negedge clk);
      u_if.op = 4'd5; u_if.SrcA = 32'hCAFE0001;
      for (int unsigned i = 0; i < cyc; i++) begin
         chk("held_busy", 64'(u_if.busy), 64'd1);
         @(negedge clk);
      end
      chk("held_done_busy", 64'(u_if.busy), 64'd0);
      chk("held_done_hilo", {u_if.HI, u_if.LO}, {eh, el});
      m_hi = eh; m_lo = el;
      @(negedge clk);
      u_if.start = 1'b0;
      m_hi = 32'hCAFE0001;
      chk("held_mthi", {u_if.HI, u_if.LO}, {m_hi, m_lo});

      // cancel and busy both block a mult queued behind a div
      ref_op(4'd3, 32'd100, 32'd7, cyc, eh, el);
      u_if.start = 1'b1; u_if.op = 4'd3; u_if.SrcA = 32'd100; u_if.SrcB = 32'd7;
      @(negedge clk);
      u_if.op = 4'd1; u_if.SrcA = 32'd3; u_if.SrcB = 32'd3; u_if.cancel = 1'b1;
      for (int unsigned i = 0; i < cyc; i++) begin
         chk("cancel_busy", 64'(u_if.busy), 64'd1);
         @(negedge clk);
      end
      chk("cancel_div_hilo", {u_if.HI, u_if.LO}, {eh, el});
      m_hi = eh; m_lo = el;
      @(negedge clk);
      chk("cancel_block_busy", 64'(u_if.busy), 64'd0);
      chk("cancel_block_hilo", {u_if.HI, u_if.LO}, {m_hi, m_lo});
      u_if.start = 1'b0; u_if.cancel = 1'b0;

      // reset in the fourth busy cycle of a div abandons it
      u_if.start = 1'b1; u_if.op = 4'd3; u_if.SrcA = 32'd1000; u_if.SrcB = 32'd3;
      @(negedge clk);
      u_if.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_busy_before", 64'(u_if.busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(u_if.busy), 64'd0);
      chk("rst_mid_hilo", {u_if.HI, u_if.LO}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = '0; m_lo = '0;
      for (int unsigned i = 0; i < 12; i++) begin
         chk("rst_after_busy", 64'(u_if.busy), 64'd0);
         chk("rst_after_hilo", {u_if.HI, u_if.LO}, 64'd0);
         @(negedge clk);
      end

      // accumulate: HI:LO = 0:FFFFFFFF, then maddu 1*1
      run_op(4'd5, 32'd0, 32'd0, "mthi0");
      run_op(4'd6, 32'hFFFFFFFF, 32'd0, "mtloF");
      run_op(4'd8, 32'd1, 32'd1, "maddu");
      chk("maddu_abs", {u_if.HI, u_if.LO}, MADD ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);
      run_op(4'd7, 32'hFFFFFFFF, 32'd5, "madd");
      run_op(4'd9, 32'h7FFFFFFF, 32'h80000000, "msub");
      run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, "msubu");

      for (int unsigned n = 0; n < 48; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = $urandom_range(1, 9);
            2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            default: ;
         endcase
         run_op(rop, ra, rb, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
